// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D-cache to main-memory arbiter.
// States, grant encoding and line/address widths.
package mem_arb_pkg;

  localparam int LINE_W  = 64;
  localparam int LADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker.
// A lone request always wins; a tie goes to the side not granted last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  gnt_t last_grant,
  output logic any,
  output gnt_t grant
);

  assign any = i_req | d_req;

  always_comb begin
    grant = GNT_I;
    unique case (1'b1)
      (i_req && d_req): begin
        grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
      end
      (d_req && !i_req): begin
        grant = GNT_D;
      end
      default: begin
        grant = GNT_I;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one main-memory port between the I-cache and D-cache.
// IDLE grants, BUSY strobes memory for MEM_LAT cycles, DONE pulses the ack.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int LINE_W  = mem_arb_pkg::LINE_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_req,
  input  logic [mem_arb_pkg::LADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0]               i_rdata,
  output logic                            i_ack,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [mem_arb_pkg::LADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0]               d_wdata,
  output logic [LINE_W-1:0]               d_rdata,
  output logic                            d_ack,
  output logic                            mem_re,
  output logic                            mem_we,
  output logic [mem_arb_pkg::LADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]               mem_wdata,
  input  logic [LINE_W-1:0]               mem_rdata,
  output logic                            busy
);

  import mem_arb_pkg::*;

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_t state;
  state_t state_n;
  gnt_t   last_gnt;
  gnt_t   gnt;
  gnt_t   pick;

  logic               any_req;
  logic               issue;
  logic               last_beat;
  logic               we_q;
  logic [CW-1:0]      cnt;
  logic [LADDR_W-1:0] addr_q;
  logic [LINE_W-1:0]  wdata_q;
  logic [LINE_W-1:0]  i_rdata_q;
  logic [LINE_W-1:0]  d_rdata_q;

  mem_arb_rr u_rr (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_gnt),
    .any        (any_req),
    .grant      (pick)
  );

  assign issue     = (state == IDLE) && any_req;
  assign last_beat = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Winner's request is frozen here; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= GNT_D;
      gnt      <= GNT_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
    end else if (issue) begin
      last_gnt <= pick;
      gnt      <= pick;
      we_q     <= (pick == GNT_D) && d_we;
      addr_q   <= (pick == GNT_D) ? d_addr : i_addr;
      wdata_q  <= d_wdata;
      cnt      <= CNT_INIT;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (last_beat && !we_q) begin
      if (gnt == GNT_I) begin
        i_rdata_q <= mem_rdata;
      end else begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_re    = (state == BUSY) && !we_q;
  assign mem_we    = (state == BUSY) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = (state == DONE) && (gnt == GNT_I);
  assign d_ack     = (state == DONE) && (gnt == GNT_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic.
// A transaction-level model predicts every output on every cycle.
module tb_mem_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [13:0] i_addr = '0;
  logic [63:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [13:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic        mem_re;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        busy;

  logic        i_req1 = 1'b0;
  logic [13:0] i_addr1 = '0;
  logic [63:0] i_rdata1;
  logic        i_ack1;
  logic [63:0] d_rdata1;
  logic        d_ack1;
  logic        mem_re1;
  logic        mem_we1;
  logic [13:0] mem_addr1;
  logic [63:0] mem_wdata1;
  logic [63:0] mem_rdata1 = '0;
  logic        busy1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(L), .LINE_W(64)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(1), .LINE_W(64)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(14'h0), .d_wdata(64'h0),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_re(mem_re1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] dut_mem [int];
  logic [63:0] mdl_mem [int];

  function automatic logic [63:0] dflt(input int a);
    logic [15:0] h;
    h = a[15:0];
    return {h ^ 16'h5a5a, 16'(h * 3), ~h, 16'(h + 7)};
  endfunction

  function automatic logic [63:0] rd_dut(input int a);
    if (dut_mem.exists(a)) return dut_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [63:0] rd_mdl(input int a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return dflt(a);
  endfunction

  // Transaction-level model: one grant at a time, timed from its start cycle.
  bit          act = 0;
  bit          ended = 0;
  int          s = 0;
  bit          who_d = 0;
  bit          last_d = 1;
  bit          mwe = 0;
  logic [13:0] maddr = '0;
  logic [63:0] mwd = '0;
  logic [63:0] e_ir = '0;
  logic [63:0] e_dr = '0;
  int          cyc = 0;

  int          ack_q[$];
  int          ack_t[$];
  int          re_cnt = 0;
  int          we_cnt = 0;
  logic [13:0] re_addr = '0;
  logic [63:0] we_data = '0;

  int mode = 0;
  bit i_gone = 0;
  bit d_gone = 0;

  task automatic tick();
    int  k;
    bit  e_busy, e_re, e_we, e_ia, e_da;
    @(posedge clk);
    #1;
    cyc++;
    ended = 0;
    if (mem_we) dut_mem[int'(mem_addr)] = mem_wdata;
    mem_rdata = rd_dut(int'(mem_addr));
    k = act ? (cyc - s) : 0;
    e_busy = act && k >= 1 && k <= L + 1;
    e_re = act && k >= 1 && k <= L && !mwe;
    e_we = act && k >= 1 && k <= L && mwe;
    e_ia = act && k == L + 1 && !who_d;
    e_da = act && k == L + 1 && who_d;
    if (act && k == L + 1) begin
      if (mwe) mdl_mem[int'(maddr)] = mwd;
      else if (who_d) e_dr = rd_mdl(int'(maddr));
      else e_ir = rd_mdl(int'(maddr));
    end
    check("busy", busy, e_busy);
    check("mem_re", mem_re, e_re);
    check("mem_we", mem_we, e_we);
    check("i_ack", i_ack, e_ia);
    check("d_ack", d_ack, e_da);
    check("i_rdata", i_rdata, e_ir);
    check("d_rdata", d_rdata, e_dr);
    if (e_re || e_we) check("mem_addr", mem_addr, maddr);
    if (e_we) check("mem_wdata", mem_wdata, mwd);
    if (!rst) begin
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
    end
    if (i_ack) begin ack_q.push_back(0); ack_t.push_back(cyc); end
    if (d_ack) begin ack_q.push_back(1); ack_t.push_back(cyc); end
    if (mem_re) begin re_cnt++; re_addr = mem_addr; end
    if (mem_we) begin we_cnt++; we_data = mem_wdata; end
    if (act && k == L + 1) begin
      act = 0;
      ended = 1;
    end
  endtask

  task automatic smp();
    if (rst && !act && !ended && (i_req || d_req)) begin
      who_d = (i_req && d_req) ? !last_d : d_req;
      last_d = who_d;
      act = 1;
      s = cyc;
      mwe = who_d && d_we;
      maddr = who_d ? d_addr : i_addr;
      mwd = d_wdata;
    end
  endtask

  function automatic logic [13:0] rnd_addr();
    int r;
    r = $urandom_range(9);
    if (r == 8) return 14'h3FFF;
    if (r == 9) return 14'h2000;
    return 14'(r);
  endfunction

  task automatic drive();
    if (i_ack) begin i_gone = 0; if (mode != 1) i_req = 0; end
    if (d_ack) begin d_gone = 0; if (mode != 1) d_req = 0; end
    if (mode == 2 && !i_ack) begin
      if (i_req && act && !who_d && $urandom_range(7) == 0) begin
        i_req = 0;
        i_gone = 1;
        i_addr = rnd_addr();
      end else if (!i_req && !i_gone && $urandom_range(3) == 0) begin
        i_req = 1;
        i_addr = rnd_addr();
      end
    end
    if (mode == 2 && !d_ack) begin
      if (d_req && act && who_d && $urandom_range(5) == 0) begin
        d_addr = rnd_addr();
        d_wdata = {$urandom, $urandom};
        d_we = 1'($urandom_range(1));
        if ($urandom_range(1) == 0) begin d_req = 0; d_gone = 1; end
      end else if (!d_req && !d_gone && $urandom_range(3) == 0) begin
        d_req = 1;
        d_we = 1'($urandom_range(1));
        d_addr = rnd_addr();
        d_wdata = {$urandom, $urandom};
      end
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin
      tick();
      drive();
      smp();
    end
  endtask

  task automatic clr_log();
    ack_q.delete();
    ack_t.delete();
    re_cnt = 0;
    we_cnt = 0;
  endtask

  int c0;
  logic [63:0] keep_dr;

  initial begin
    tick();
    tick();
    check("rst_i_rdata1", i_rdata1, 0);
    check("rst_busy1", busy1, 0);
    rst = 1'b1;

    // tie straight after reset: I first, then D
    tick(); drive();
    i_req = 1; i_addr = 14'h0001;
    d_req = 1; d_we = 0; d_addr = 14'h0002;
    smp();
    c0 = cyc;
    clr_log();
    cyc_n(14);
    check("tie_n", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      check("tie_first", ack_q[0], 0);
      check("tie_first_t", ack_t[0] - c0, L + 1);
      check("tie_second", ack_q[1], 1);
      check("tie_second_t", ack_t[1] - c0, 2 * L + 3);
    end

    // single fill
    dut_mem[16] = 64'h1111_2222_3333_4444;
    mdl_mem[16] = 64'h1111_2222_3333_4444;
    tick(); drive();
    i_req = 1; i_addr = 14'h0010;
    smp();
    c0 = cyc;
    clr_log();
    cyc_n(8);
    check("fill_re_cycles", re_cnt, L);
    check("fill_addr", re_addr, 14'h0010);
    check("fill_n", ack_q.size(), 1);
    if (ack_q.size() == 1) check("fill_lat", ack_t[0] - c0, L + 1);
    check("fill_data", i_rdata, 64'h1111_2222_3333_4444);

    // writeback, then read it back
    keep_dr = e_dr;
    tick(); drive();
    d_req = 1; d_we = 1; d_addr = 14'h3FFF;
    d_wdata = 64'hDEAD_BEEF_0000_FFFF;
    smp();
    clr_log();
    cyc_n(8);
    check("wb_we_cycles", we_cnt, L);
    check("wb_re_cycles", re_cnt, 0);
    check("wb_data", we_data, 64'hDEAD_BEEF_0000_FFFF);
    check("wb_n", ack_q.size(), 1);
    if (ack_q.size() == 1) check("wb_side", ack_q[0], 1);
    check("wb_rdata_kept", d_rdata, keep_dr);
    tick(); drive();
    d_req = 1; d_we = 0; d_addr = 14'h3FFF; d_wdata = '0;
    smp();
    cyc_n(8);
    check("wb_readback", d_rdata, 64'hDEAD_BEEF_0000_FFFF);

    // fairness with both requests held
    mode = 1;
    tick(); drive();
    i_req = 1; d_req = 1; d_we = 0;
    smp();
    c0 = cyc;
    clr_log();
    cyc_n(4 * (L + 2) + 1);
    check("fair_n", ack_q.size(), 4);
    if (ack_q.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check("fair_side", ack_q[j], j % 2);
        check("fair_t", ack_t[j] - c0, j * (L + 2) + L + 1);
      end
    end
    mode = 0;
    cyc_n(2 * (L + 2) + 2);
    i_req = 0; d_req = 0;
    cyc_n(2);

    // reset during the second BUSY cycle
    tick(); drive();
    i_req = 1; i_addr = 14'h0005;
    smp();
    cyc_n(1);
    tick();
    rst = 1'b0;
    #1;
    act = 0; last_d = 1; e_ir = '0; e_dr = '0;
    check("rst_mid_re", mem_re, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ack", i_ack, 0);
    check("rst_mid_rdata", i_rdata, 0);
    clr_log();
    tick();
    tick();
    rst = 1'b1;
    smp();
    c0 = cyc;
    cyc_n(8);
    check("rst_ack_n", ack_q.size(), 1);
    if (ack_q.size() == 1) check("rst_ack_t", ack_t[0] - c0, L + 1);

    // random traffic
    mode = 2;
    cyc_n(3000);
    mode = 0;
    cyc_n(40);
    i_req = 0; d_req = 0;
    cyc_n(2);

    // MEM_LAT=1 instance: one strobe cycle, ack in the next
    tick();
    i_req1 = 1; i_addr1 = 14'h0020;
    mem_rdata1 = 64'hA5A5_0F0F_1234_5678;
    tick();
    check("l1_re", mem_re1, 1);
    check("l1_addr", mem_addr1, 14'h0020);
    check("l1_busy", busy1, 1);
    tick();
    check("l1_re_off", mem_re1, 0);
    check("l1_ack", i_ack1, 1);
    check("l1_data", i_rdata1, 64'hA5A5_0F0F_1234_5678);
    i_req1 = 0;
    tick();
    check("l1_ack_off", i_ack1, 0);
    check("l1_idle", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
